// File: rtl/cpu_fetch_ctrl.sv
// Fetch sequencer for the CPU front end. Owns the PC register write port,
// issues one instruction-bus read at a time, hands words to decode, and
// arbitrates PC updates between trap entry, redirects and sequential advance.
module cpu_fetch_ctrl #(
  parameter logic [31:0] TRAP_VECTOR = 32'h40000100,
  parameter int          INST_BYTES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] curr_pc,
  output logic [31:0] next_pc,
  output logic        pc_wr,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_req,
  input  logic        halt,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    START,
    FETCH,
    HOLD,
    DRAIN,
    HALTED
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] drain_addr;
  logic        capture;
  logic        take_trap;
  logic        take_redir;
  logic        redir_misaligned;
  logic        pc_override;

  // State register; reset lands in START so every output is quiet at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= START;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the fetched word for decode and remember the in-flight address
  // when a redirect forces us to drain an outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst       <= '0;
      inst_pc    <= '0;
      drain_addr <= '0;
    end else begin
      if (capture) begin
        inst    <= ibus_rdata;
        inst_pc <= curr_pc;
      end
      if (state == FETCH && state_nxt == DRAIN) begin
        drain_addr <= curr_pc;
      end
    end
  end

  // Next-state, PC-write arbitration (trap > redirect > sequential) and bus
  // outputs. curr_pc only moves on our own pc_wr, so it is stable while FETCH
  // waits for ack; DRAIN needs the saved address because the PC has moved on.
  always_comb begin
    state_nxt        = state;
    pc_wr            = 1'b0;
    next_pc          = '0;
    fetch_fault      = 1'b0;
    ibus_req         = 1'b0;
    ibus_addr        = '0;
    capture          = 1'b0;
    take_trap        = (state != START) && trap_req;
    take_redir       = (state != START) && redirect_valid && !trap_req;
    redir_misaligned = (redirect_pc[1:0] != 2'b00);
    pc_override      = take_trap || take_redir;

    if (take_trap) begin
      pc_wr   = 1'b1;
      next_pc = TRAP_VECTOR;
    end else if (take_redir) begin
      pc_wr = 1'b1;
      if (redir_misaligned) begin
        next_pc     = TRAP_VECTOR;
        fetch_fault = 1'b1;
      end else begin
        next_pc = redirect_pc;
      end
    end

    case (state)
      START: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        ibus_req  = 1'b1;
        ibus_addr = curr_pc;
        if (pc_override) begin
          // A word returning with the redirect is dropped; without ack the
          // outstanding request must still be drained.
          state_nxt = ibus_ack ? FETCH : DRAIN;
        end else if (ibus_ack) begin
          pc_wr = 1'b1;
          if (ibus_err) begin
            fetch_fault = 1'b1;
            next_pc     = TRAP_VECTOR;
            state_nxt   = FETCH;
          end else begin
            capture   = 1'b1;
            next_pc   = curr_pc + 32'(INST_BYTES);
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (pc_override || inst_ready) begin
          state_nxt = halt ? HALTED : FETCH;
        end
      end
      DRAIN: begin
        ibus_req  = 1'b1;
        ibus_addr = drain_addr;
        if (ibus_ack) begin
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        if (!pc_override && !halt) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = START;
      end
    endcase
  end

  assign inst_valid = (state == HOLD);

endmodule
